// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter sharing one Keccak permutation core between three requesters.
// A watchdog aborts a run whose core never signals completion.
module keccak_perm_arbiter #(
  parameter int STATE_W = 1600,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           req,
  input  logic [3*STATE_W-1:0] ain,
  output logic [2:0]           ack,
  output logic [3*STATE_W-1:0] aout,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic                 err,
  output logic                 core_start,
  output logic [STATE_W-1:0]   core_ain,
  input  logic [STATE_W-1:0]   core_aout,
  input  logic                 core_done,
  output logic [1:0]           dbg_state_o
);

  // Core handshake: core_start is held high (with core_ain frozen) for the whole
  // run; the core raises core_done as a level and keeps it while core_start is
  // high. core_done is only honoured in RUN, and DRAIN guarantees start is seen
  // low for at least one cycle before the next grant.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           rr_q, rr_d;
  logic [7:0]           wdog_q, wdog_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic [2:0]           ack_q, ack_d;
  logic                 load_ain;
  logic                 write_aout;
  logic [STATE_W-1:0]   core_ain_q;
  logic [3*STATE_W-1:0] aout_q;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First set request at or after the pointer, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] c0, c1, c2;
    c0 = p;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (r[c0])      return c0;
    else if (r[c1]) return c1;
    else            return c2;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    start_d    = start_q;
    ack_d      = 3'b000;
    load_ain   = 1'b0;
    write_aout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        if (req != 3'b000) begin
          owner_d  = rr_pick(req, rr_q);
          load_ain = 1'b1;
          wdog_d   = 8'd0;
          start_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        start_d = 1'b1;
        if (core_done) begin
          write_aout     = 1'b1;
          ack_d[owner_q] = 1'b1;
          start_d        = 1'b0;
          rr_d           = inc3(owner_q);
          state_d        = S_DRAIN;
        end else begin
          wdog_d = wdog_q + 8'd1;
          // Abort leaves the owner's result register untouched.
          if (wdog_d == TIMEOUT_C) begin
            err_d          = 1'b1;
            ack_d[owner_q] = 1'b1;
            start_d        = 1'b0;
            rr_d           = inc3(owner_q);
            state_d        = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      rr_q    <= 2'd0;
      wdog_q  <= 8'd0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      start_q <= start_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      core_ain_q <= '0;
      aout_q     <= '0;
    end else begin
      if (load_ain)
        core_ain_q <= ain[int'(owner_d)*STATE_W +: STATE_W];
      if (write_aout)
        aout_q[int'(owner_q)*STATE_W +: STATE_W] <= core_aout;
    end
  end

  assign ack         = ack_q;
  assign aout        = aout_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign owner       = owner_q;
  assign err         = err_q;
  assign core_start  = start_q;
  assign core_ain    = core_ain_q;
  assign dbg_state_o = state_q;

endmodule
